dmem_rv: RTL and testbench

Byte-addressed RISC-V data memory with sub-word access, replacing the word-only data memory on the core's load/store path. Accepts one load or store per handshake and decodes RV32I `funct3` for byte, half-word and word widths, with sign or zero extension on loads. Flags misaligned and illegal accesses instead of performing them. A programmable number of wait states lets the pipeline's stall logic be exercised against a slow memory.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_be_ram.sv | 21 ++
 rtl/dmem_rv.sv | 94 +++++++++
 tb/tb_dmem_rv.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM states and access decode shared by the data memory.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} dmem_state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] be;
    } dmem_dec_t;

    function automatic dmem_dec_t dmem_decode(input logic we, input logic [2:0] f3, input logic [1:0] a);
        dmem_dec_t d;
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (!we && (f3 == F3_BU || f3 == F3_HU));
        d.be = (f3[1:0] == 2'b00) ? 4'b0001 << a : (f3[1:0] == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        d.err = !legal || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return d;
    endfunction
endpackage

// File: rtl/dmem_be_ram.sv
// dmem_be_ram: 32-bit synchronous RAM with byte write enables and registered read.
module dmem_be_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_rv.sv
// dmem_rv: byte-addressed RV32I data memory with sub-word access, error flagging and wait states.
module dmem_rv
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              l_we, r_we, a_we, accept, access;
    logic [2:0]        l_f3, r_f3, a_f3;
    logic [ADDR_W-1:0] l_addr, a_addr;
    logic [31:0]       l_wdata, a_wdata, wlanes, q, ext;
    logic [1:0]        r_a;
    logic [7:0]        b;
    logic [15:0]       h;
    dmem_dec_t         dec;

    // With no wait states the access happens on the accept edge, so the live request is used.
    always_comb begin
        req_ready = !rst && (state == S_IDLE || state == S_RESP);
        accept    = req_valid && req_ready;
        a_we      = (WAIT_CYCLES == 0) ? req_we : l_we;
        a_f3      = (WAIT_CYCLES == 0) ? req_funct3 : l_f3;
        a_addr    = (WAIT_CYCLES == 0) ? req_addr : l_addr;
        a_wdata   = (WAIT_CYCLES == 0) ? req_wdata : l_wdata;
        access    = !rst && ((WAIT_CYCLES == 0) ? accept : (state == S_WAIT && cnt == 4'd1));
        dec       = dmem_decode(a_we, a_f3, a_addr[1:0]);
        wlanes    = (a_f3[1:0] == 2'b00) ? {4{a_wdata[7:0]}} : (a_f3[1:0] == 2'b01) ? {2{a_wdata[15:0]}} : a_wdata;
        b         = q[{r_a, 3'b000} +: 8];
        h         = r_a[1] ? q[31:16] : q[15:0];
        ext       = (r_f3 == F3_B) ? {{24{b[7]}}, b} : (r_f3 == F3_H) ? {{16{h[15]}}, h} :
                    (r_f3 == F3_BU) ? {24'b0, b} : (r_f3 == F3_HU) ? {16'b0, h} : q;
        rsp_rdata = (rsp_valid && !rsp_err && !r_we) ? ext : 32'b0;
    end

    dmem_be_ram #(.AW(ADDR_W - 2)) u_ram (
        .clk   (clk),
        .en    (access),
        .we    ((a_we && !dec.err) ? dec.be : 4'b0000),
        .addr  (a_addr[ADDR_W-1:2]),
        .wdata (wlanes),
        .rdata (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= access;
            rsp_err   <= access && dec.err;
            if (accept) begin
                state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                cnt   <= WC;
            end else if (state == S_WAIT) begin
                state <= (cnt == 4'd1) ? S_RESP : S_WAIT;
                cnt   <= cnt - 4'd1;
            end else begin
                state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            l_we    <= req_we;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
        end
        if (access) begin
            r_we <= a_we;
            r_f3 <= a_f3;
            r_a  <= a_addr[1:0];
        end
    end
endmodule

// File: tb/tb_dmem_rv.sv
// tb_dmem_rv: directed checks of dmem_rv with zero and three wait states.
module tb_dmem_rv;
    logic        clk = 1'b0;
    logic        rst0, v0, we0, rdy0, rv0, err0;
    logic [2:0]  f30;
    logic [9:0]  a0;
    logic [31:0] wd0, rd0;
    logic        rst3, v3, we3, rdy3, rv3, err3;
    logic [2:0]  f33;
    logic [9:0]  a3;
    logic [31:0] wd3, rd3;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_rv #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_funct3(f30),
        .req_addr(a0), .req_wdata(wd0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
    );

    dmem_rv #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_funct3(f33),
        .req_addr(a3), .req_wdata(wd3), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact0(input string tag, input logic we, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        v0 = 1'b1; we0 = we; f30 = f3; a0 = a; wd0 = wd;
        check({tag, " ready"}, 32'(rdy0), 32'd1);
        tick();
        v0 = 1'b0;
        check({tag, " valid"}, 32'(rv0), 32'd1);
        check({tag, " rdata"}, rd0, ed);
        check({tag, " err"}, 32'(err0), 32'(ee));
        tick();
        check({tag, " idle"}, 32'(rv0), 32'd0);
    endtask

    task automatic xact3(input string tag, input logic we, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        int lat;
        v3 = 1'b1; we3 = we; f33 = f3; a3 = a; wd3 = wd;
        check({tag, " ready"}, 32'(rdy3), 32'd1);
        tick();
        v3 = 1'b0;
        lat = 1;
        while (!rv3 && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " rdata"}, rd3, ed);
        check({tag, " err"}, 32'(err3), 32'(ee));
        tick();
        check({tag, " idle"}, 32'(rv3), 32'd0);
    endtask

    // Store accepted, then rst asserted during cycle rc after acceptance (cycle 0).
    task automatic rst_abort(input int rc);
        v3 = 1'b1; we3 = 1'b1; f33 = 3'b010; a3 = 10'h020; wd3 = 32'h11111111;
        tick();
        v3 = 1'b0;
        for (int c = 1; c < rc; c++) tick();
        rst3 = 1'b1;
        v3 = 1'b1; wd3 = 32'h33333333;
        check("rst ready", 32'(rdy3), 32'd0);
        tick();
        rst3 = 1'b0;
        v3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("rst no rsp", 32'(rv3), 32'd0);
            tick();
        end
        xact3("rst lw", 1'b0, 3'b010, 10'h020, 32'h0, 32'h22222222, 1'b0);
    endtask

    initial begin
        rst0 = 1'b1; v0 = 1'b1; we0 = 1'b1; f30 = 3'b010; a0 = 10'h010; wd0 = 32'h0BADF00D;
        rst3 = 1'b1; v3 = 1'b1; we3 = 1'b0; f33 = 3'b010; a3 = 10'h020; wd3 = 32'h0;
        tick();
        check("reset ready0", 32'(rdy0), 32'd0);
        check("reset ready3", 32'(rdy3), 32'd0);
        tick();
        check("reset valid0", 32'(rv0), 32'd0);
        check("reset rdata0", rd0, 32'd0);
        check("reset err0", 32'(err0), 32'd0);
        check("reset valid3", 32'(rv3), 32'd0);
        rst0 = 1'b0; rst3 = 1'b0; v0 = 1'b0; v3 = 1'b0;
        tick();
        check("post reset idle0", 32'(rv0), 32'd0);

        // Back-to-back store then load, the load accepted in the store's response cycle.
        v0 = 1'b1; we0 = 1'b1; f30 = 3'b010; a0 = 10'h010; wd0 = 32'hDEADBEEF;
        check("b2b sw ready", 32'(rdy0), 32'd1);
        tick();
        we0 = 1'b0; wd0 = 32'h0;
        check("b2b sw valid", 32'(rv0), 32'd1);
        check("b2b sw rdata", rd0, 32'd0);
        check("b2b sw err", 32'(err0), 32'd0);
        check("b2b lw ready", 32'(rdy0), 32'd1);
        tick();
        v0 = 1'b0;
        check("b2b lw valid", 32'(rv0), 32'd1);
        check("b2b lw rdata", rd0, 32'hDEADBEEF);
        tick();
        check("b2b idle", 32'(rv0), 32'd0);

        xact0("lb", 1'b0, 3'b000, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact0("lbu", 1'b0, 3'b100, 10'h013, 32'h0, 32'h000000DE, 1'b0);
        xact0("lh", 1'b0, 3'b001, 10'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
        xact0("lhu", 1'b0, 3'b101, 10'h010, 32'h0, 32'h0000BEEF, 1'b0);
        xact0("lbu lane0", 1'b0, 3'b100, 10'h010, 32'h0, 32'h000000EF, 1'b0);
        xact0("sb", 1'b1, 3'b000, 10'h011, 32'hABCDEF5A, 32'h0, 1'b0);
        xact0("lw after sb", 1'b0, 3'b010, 10'h010, 32'h0, 32'hDEAD5AEF, 1'b0);
        xact0("sh", 1'b1, 3'b001, 10'h012, 32'h99991234, 32'h0, 1'b0);
        xact0("lw after sh", 1'b0, 3'b010, 10'h010, 32'h0, 32'h12345AEF, 1'b0);
        xact0("lh positive", 1'b0, 3'b001, 10'h012, 32'h0, 32'h00001234, 1'b0);
        xact0("lb positive", 1'b0, 3'b000, 10'h011, 32'h0, 32'h0000005A, 1'b0);
        xact0("lw misaligned", 1'b0, 3'b010, 10'h012, 32'h0, 32'h0, 1'b1);
        xact0("lh misaligned", 1'b0, 3'b001, 10'h011, 32'h0, 32'h0, 1'b1);
        xact0("sh misaligned", 1'b1, 3'b001, 10'h011, 32'h0000FFFF, 32'h0, 1'b1);
        xact0("sw misaligned", 1'b1, 3'b010, 10'h012, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact0("lw unchanged", 1'b0, 3'b010, 10'h010, 32'h0, 32'h12345AEF, 1'b0);
        xact0("load f3 011", 1'b0, 3'b011, 10'h010, 32'h0, 32'h0, 1'b1);
        xact0("store f3 100", 1'b1, 3'b100, 10'h010, 32'h000000FF, 32'h0, 1'b1);
        xact0("lw after illegal", 1'b0, 3'b010, 10'h010, 32'h0, 32'h12345AEF, 1'b0);

        xact3("w3 sw", 1'b1, 3'b010, 10'h020, 32'h22222222, 32'h0, 1'b0);

        // Request held valid through the wait cycles must not be taken.
        v3 = 1'b1; we3 = 1'b0; f33 = 3'b010; a3 = 10'h020;
        check("hold ready c0", 32'(rdy3), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("hold ready wait", 32'(rdy3), 32'd0);
            check("hold valid wait", 32'(rv3), 32'd0);
        end
        tick();
        v3 = 1'b0;
        check("hold valid c4", 32'(rv3), 32'd1);
        check("hold rdata c4", rd3, 32'h22222222);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold no extra rsp", 32'(rv3), 32'd0);
        end

        xact3("w3 lb", 1'b0, 3'b000, 10'h023, 32'h0, 32'h00000022, 1'b0);
        xact3("w3 lw misaligned", 1'b0, 3'b010, 10'h021, 32'h0, 32'h0, 1'b1);
        rst_abort(2);
        rst_abort(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
